// File: rtl/simon_decrypt_pkg.sv
// Shared Simon 32/64 constants, FSM encoding and round/key-schedule functions.
// Purely declarative; imported by the decryption core and its key-step unit.
package simon_pkg;

    localparam int WORD_W       = 16;
    localparam int NROUNDS      = 32;
    localparam int EXPAND_STEPS = 28;

    localparam logic [15:0] KEY_C = 16'hfffc;

    // Written in sequence order: the leftmost bit is z[0].
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXPAND  = 2'd1,
        ST_DECRYPT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [15:0] simon_f(input logic [15:0] v);
        return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
    endfunction

    function automatic logic z_bit(input logic [5:0] idx);
        return Z0[6'd61 - idx];
    endfunction

    // T ^ S-1 T with T = S-3 a ^ b; common to both schedule directions.
    function automatic logic [15:0] key_mix(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] t;
        t = {a[2:0], a[15:3]} ^ b;
        return t ^ {t[0], t[15:1]};
    endfunction

    function automatic logic [15:0] key_word(input logic [15:0] base,
                                             input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [5:0]  zi);
        return base ^ KEY_C ^ {15'd0, z_bit(zi)} ^ key_mix(a, b);
    endfunction

endpackage

// File: rtl/simon_decrypt_key_step.sv
// One Simon 32/64 key-schedule step, forward or backward, over a 4-word window.
// Combinational; a single mixer is shared by muxing the window operands.
module simon_key_step
    import simon_pkg::*;
(
    input  logic             dir_back,
    input  logic [3:0][15:0] win,
    input  logic [5:0]       z_idx,
    output logic [15:0]      new_word
);

    logic [15:0] base;
    logic [15:0] mix_a;
    logic [15:0] mix_b;

    // Forward: k[i+4] from k[i], k[i+3], k[i+1]; backward: k[i-1] from k[i+3], k[i+2], k[i].
    always_comb begin
        base  = win[0];
        mix_a = win[3];
        mix_b = win[1];
        if (dir_back) begin
            base  = win[3];
            mix_a = win[2];
            mix_b = win[0];
        end
    end

    assign new_word = key_word(base, mix_a, mix_b, z_idx);

endmodule

// File: rtl/simon_decrypt.sv
// Iterative Simon 32/64 decryption: 28 key-expansion cycles then 32 inverse rounds.
// Result 60 cycles after acceptance, held in DONE until out_ready; input blocked while busy.
module simon_decrypt
    import simon_pkg::*;
#(
    parameter int word_width = 16,
    parameter int rounds     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*word_width-1:0] ct,
    input  logic [4*word_width-1:0] key,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*word_width-1:0] pt
);

    state_t           state;
    logic [4:0]       cnt;
    logic [15:0]      x;
    logic [15:0]      y;
    logic [3:0][15:0] w;
    logic [15:0]      new_word;
    logic [5:0]       z_idx;
    logic             dir_back;

    // Backward steps from cnt 28 on make words that never reach w3 before the last round.
    always_comb begin
        dir_back = (state == ST_DECRYPT);
        z_idx    = {1'b0, cnt};
        if (dir_back) begin
            z_idx = (cnt <= 5'(EXPAND_STEPS - 1)) ? 6'(EXPAND_STEPS - 1) - {1'b0, cnt} : 6'd0;
        end
    end

    simon_key_step u_key_step (
        .dir_back (dir_back),
        .win      (w),
        .z_idx    (z_idx),
        .new_word (new_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            x     <= 16'd0;
            y     <= 16'd0;
            w     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x     <= ct[31:16];
                        y     <= ct[15:0];
                        w     <= key;
                        cnt   <= 5'd0;
                        state <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    w <= {new_word, w[3:1]};
                    if (cnt == 5'(EXPAND_STEPS - 1)) begin
                        cnt   <= 5'd0;
                        state <= ST_DECRYPT;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_DECRYPT: begin
                    x <= y;
                    y <= x ^ simon_f(y) ^ w[3];
                    w <= {w[2:0], new_word};
                    if (cnt == 5'(rounds - 1)) begin
                        cnt   <= 5'd0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign pt        = {x, y};

endmodule

// File: tb/tb_simon_decrypt.sv
// Bench for simon_decrypt: Simon 32/64 reference model, per-cycle scoreboard, directed tests.
module tb_simon_decrypt;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ct;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    simon_decrypt dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
    localparam logic [31:0] KAT_CT  = 32'hc69be9bb;
    localparam logic [31:0] KAT_PT  = 32'h65656877;

    string zseq = "11111010001001010110000111001101111101000100101011000011100110";

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] v, input int j);
        return (v << j) | (v >> (16 - j));
    endfunction

    function automatic logic [15:0] ff(input logic [15:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic logic [31:0] m_crypt(input logic [63:0] kk, input logic [31:0] blk,
                                            input bit decrypt);
        logic [15:0] k [0:31];
        logic [15:0] xx, yy, t, tmp;
        for (int i = 0; i < 4; i++) k[i] = kk[16*i +: 16];
        for (int i = 0; i < 28; i++) begin
            tmp = rotl(k[i+3], 13) ^ k[i+1];
            tmp = tmp ^ rotl(tmp, 15);
            k[i+4] = ~k[i] ^ tmp ^ 16'd3 ^ ((zseq[i % 62] == 8'h31) ? 16'd1 : 16'd0);
        end
        xx = blk[31:16];
        yy = blk[15:0];
        for (int r = 0; r < 32; r++) begin
            if (decrypt) begin
                t  = yy;
                yy = xx ^ ff(t) ^ k[31-r];
                xx = t;
            end else begin
                t  = xx;
                xx = yy ^ ff(t) ^ k[r];
                yy = t;
            end
        end
        return {xx, yy};
    endfunction

    // Scoreboard: expected handshake behaviour and plaintext, checked every falling edge.
    bit          busy = 0;
    int          acc_cyc = 0;
    int          last_acc = 0;
    int          prev_acc = 0;
    int          n_acc = 0;
    int          n_done = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pt = '0;

    always @(negedge clk) begin
        bit ov_exp;
        if (!reset) begin
            busy = 0;
            exp_q.delete();
        end
        ov_exp = busy && (cyc - acc_cyc >= 60);
        chk("in_ready", in_ready, !busy);
        chk("out_valid", out_valid, ov_exp);
        if (ov_exp) begin
            chk("pt", pt, exp_q[0]);
            last_pt = pt;
        end
        if (reset) begin
            if (ov_exp && out_ready) begin
                void'(exp_q.pop_front());
                busy = 0;
                n_done++;
            end else if (!busy && in_valid) begin
                busy     = 1;
                acc_cyc  = cyc + 1;
                prev_acc = last_acc;
                last_acc = acc_cyc;
                exp_q.push_back(m_crypt(key, ct, 1'b1));
                n_acc++;
            end
        end
    end

    task automatic wait_acc(input int target);
        int b = 0;
        while (n_acc < target && b < 300) begin
            @(posedge clk); #1;
            b++;
        end
        if (n_acc < target) chk("accept_timeout", 64'(n_acc), 64'(target));
    endtask

    task automatic wait_done(input int target);
        int b = 0;
        while (n_done < target && b < 300) begin
            @(posedge clk); #1;
            b++;
        end
        if (n_done < target) chk("done_timeout", 64'(n_done), 64'(target));
    endtask

    task automatic send(input logic [63:0] kk, input logic [31:0] cc, input bit keep);
        int target;
        target   = n_acc + 1;
        key      = kk;
        ct       = cc;
        in_valid = 1'b1;
        wait_acc(target);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [63:0] kk, input logic [31:0] cc);
        int d;
        d = n_done;
        send(kk, cc, 1'b0);
        wait_done(d + 1);
    endtask

    initial begin
        int          d;
        int          b;
        logic [63:0] rk;
        logic [31:0] rp;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ct        = '0;
        key       = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_pt", pt, 32'd0);
        reset = 1'b1;

        chk("model_kat_dec", m_crypt(KAT_KEY, KAT_CT, 1'b1), KAT_PT);
        chk("model_kat_enc", m_crypt(KAT_KEY, KAT_PT, 1'b0), KAT_CT);
        chk("model_zero_rt", m_crypt(64'd0, m_crypt(64'd0, 32'd0, 1'b1), 1'b0), 32'd0);

        run_one(KAT_KEY, KAT_CT);
        chk("kat_pt", last_pt, KAT_PT);

        run_one(64'd0, 32'd0);
        chk("zero_pt", last_pt, m_crypt(64'd0, 32'd0, 1'b1));

        // Backpressure with ignored input pulses.
        out_ready = 1'b0;
        d = n_done;
        send(KAT_KEY, KAT_CT, 1'b0);
        b = 0;
        while (!out_valid && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        chk("bp_out_valid", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            ct       = $urandom;
            key      = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_pt_held", pt, KAT_PT);
        chk("bp_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready", in_ready, 1'b1);
        chk("bp_idle_out_valid", out_valid, 1'b0);
        chk("bp_done_count", 64'(n_done), 64'(d + 1));

        // Reset 40 cycles into an operation, then a fresh known-answer run.
        send(KAT_KEY, KAT_CT, 1'b0);
        repeat (39) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_one(KAT_KEY, KAT_CT);
        chk("midrst_kat_pt", last_pt, KAT_PT);

        // Back-to-back with in_valid and out_ready held high.
        d = n_done;
        send(KAT_KEY, KAT_CT, 1'b1);
        rk  = 64'h0123456789abcdef;
        rp  = 32'h5a5a1234;
        key = rk;
        ct  = m_crypt(rk, rp, 1'b0);
        wait_acc(n_acc + 1);
        in_valid = 1'b0;
        chk("b2b_spacing", 64'(last_acc - prev_acc), 64'd62);
        wait_done(d + 2);
        chk("b2b_second_pt", last_pt, rp);

        for (int i = 0; i < 200; i++) begin
            rk = {$urandom, $urandom};
            rp = $urandom;
            run_one(rk, m_crypt(rk, rp, 1'b0));
            chk("roundtrip", last_pt, rp);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
